// File: rtl/sequence_decoder_pkg.sv
// Shared constants and state encoding for the serial frame decoder.
// Frames are FRAME_LEN bits, MSB first on the line.
package sequence_decoder_pkg;

    localparam int                   FRAME_LEN = 6;
    localparam logic [FRAME_LEN-1:0] PATTERN   = 6'b100011;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sequence_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One-cycle latency from inc/clr to cnt; no backpressure.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sequence_decoder.sv
// Serial frame decoder: collects 6-bit frames (start bit = first valid 1) and flags match/error.
// Pulses and counters update on the edge that takes the 6th valid bit; din_valid=0 stalls freely.
module sequence_decoder
    import sequence_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             match,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t               state_q;
    logic [2:0]           bit_cnt_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic                 match_q;
    logic                 frame_err_q;

    logic [FRAME_LEN-1:0] shift_d;
    logic                 frame_done;
    logic                 frame_ok;
    logic                 unused_shift_msb;

    // The last bit is compared straight off the line so the verdict lands on the completing edge.
    assign shift_d          = {shift_q[FRAME_LEN-2:0], din};
    assign frame_done       = din_valid && (state_q == RECV) && (bit_cnt_q == 3'(FRAME_LEN - 1));
    assign frame_ok         = (shift_d == PATTERN);
    assign unused_shift_msb = shift_q[FRAME_LEN-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            match_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            match_q     <= frame_done && frame_ok;
            frame_err_q <= frame_done && !frame_ok;
            if (din_valid) begin
                case (state_q)
                    IDLE: begin
                        if (din) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= 3'd1;
                            state_q   <= RECV;
                        end
                    end
                    RECV: begin
                        shift_q <= shift_d;
                        if (frame_done) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign match     = match_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == RECV);

    sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (frame_done && frame_ok),
        .clr   (cnt_clr),
        .cnt   (frame_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (frame_done && !frame_ok),
        .clr   (cnt_clr),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_sequence_decoder.sv
// Directed bench: vector table for single/back-to-back frames, hand sequences for stall, reset and saturation.
module tb_sequence_decoder;

    logic       clk = 1'b0;
    logic       reset, din, din_valid, cnt_clr;
    logic       match, frame_err, busy;
    logic [7:0] frame_cnt, err_cnt;
    logic       match2, frame_err2, busy2;
    logic [1:0] frame_cnt2, err_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] PAT = 6'b100011;

    always #5 clk = ~clk;

    sequence_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .match(match), .frame_err(frame_err), .busy(busy),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    sequence_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .cnt_clr(cnt_clr),
        .match(match2), .frame_err(frame_err2), .busy(busy2),
        .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        bit         r, v, d, c;
        bit         m, e, b;
        logic [7:0] fc, ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, bit d, bit c, bit m, bit e, bit b,
                                logic [7:0] fc, logic [7:0] ec);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c;
        t.m = m; t.e = e; t.b = b; t.fc = fc; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic step(input bit r, input bit v, input bit d, input bit c);
        reset = r; din_valid = v; din = d; cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [5:0] bits, input bit clr_last, input string name);
        bit exp_m;
        exp_m = (bits == PAT);
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], (i == 0) ? clr_last : 1'b0);
            if (i > 0) begin
                chk({name, "_mid"}, {29'd0, match, frame_err, busy}, 32'b001);
            end else begin
                chk({name, "_end"}, {29'd0, match, frame_err, busy}, {29'd0, exp_m, !exp_m, 1'b0});
            end
        end
    endtask

    initial begin
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;

        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0));
        tbl.push_back(mk(1,1,1,1, 0,0,0, 0,0));
        // 100011 -> match
        tbl.push_back(mk(0,1,1,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,1,0, 1,0,0, 1,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0, 1,0));
        // 101011 -> error, no early abort
        tbl.push_back(mk(0,1,1,0, 0,0,1, 1,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 1,0));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 1,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 1,0));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 1,0));
        tbl.push_back(mk(0,1,1,0, 0,1,0, 1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 1,1));
        // two back-to-back matches, 12 consecutive valid bits
        tbl.push_back(mk(0,1,1,0, 0,0,1, 1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 1,1));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 1,1));
        tbl.push_back(mk(0,1,1,0, 1,0,0, 2,1));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 2,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 2,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 2,1));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 2,1));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 2,1));
        tbl.push_back(mk(0,1,1,0, 1,0,0, 3,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 3,1));
        // clear while idle, then clear during a frame start leaves the FSM alone
        tbl.push_back(mk(0,0,0,1, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,1,1, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,1, 0,0));
        tbl.push_back(mk(0,1,1,0, 1,0,0, 1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d", i),
                {13'd0, match, frame_err, busy, frame_cnt, err_cnt},
                {13'd0, tbl[i].m, tbl[i].e, tbl[i].b, tbl[i].fc, tbl[i].ec});
        end

        // Stall of 3 invalid cycles after bit 2
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk($sformatf("stall%0d", i), {29'd0, match, frame_err, busy}, 32'b001);
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("stall_pre", {29'd0, match, busy}, 32'b01);
        step(0, 1, 1, 0);
        chk("stall_end", {21'd0, match, frame_err, busy, frame_cnt}, {21'd0, 3'b100, 8'd1});
        step(0, 0, 0, 0);
        chk("stall_oneshot", {31'd0, match}, 32'd0);

        // Reset after bit 3 discards the partial frame
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("abort_rst", {21'd0, match, frame_err, busy, frame_cnt}, 32'd0);
        send_frame(PAT, 1'b0, "abort_full");
        chk("abort_cnt", {24'd0, frame_cnt}, 32'd1);

        // Reset coinciding with the completing bit wins
        for (int i = 5; i >= 1; i--) step(0, 1, PAT[i], 0);
        step(1, 1, PAT[0], 0);
        chk("rst_prio", {21'd0, match, frame_err, busy, frame_cnt}, 32'd0);

        // Saturation of the 2-bit counter and clear-over-increment
        step(1, 0, 0, 0);
        chk("sat_rst", {30'd0, frame_cnt2}, 32'd0);
        for (int f = 1; f <= 4; f++) begin
            send_frame(PAT, 1'b0, $sformatf("sat_f%0d", f));
            chk($sformatf("sat_cnt%0d", f), {30'd0, frame_cnt2}, (f > 3) ? 32'd3 : f);
        end
        chk("wide_cnt4", {24'd0, frame_cnt}, 32'd4);
        send_frame(PAT, 1'b1, "sat_f5");
        chk("sat_clr", {22'd0, frame_cnt2, frame_cnt}, 32'd0);
        send_frame(6'b110000, 1'b0, "err_a");
        chk("err_cnt_a", {22'd0, err_cnt2, err_cnt}, {22'd0, 2'd1, 8'd1});
        send_frame(6'b111111, 1'b1, "err_b");
        chk("err_clr", {22'd0, err_cnt2, err_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
